// File: rtl/md_unit_param_if.sv
// Handshake/data bundle between the execute stage and the multiply/divide unit.
// The master drives operands and controls; the slave returns status and HI/LO.
interface md_unit_param_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] D1;
    logic [WIDTH-1:0] D2;
    logic             Start;
    logic [1:0]       Op;
    logic             HIWe;
    logic             LOWe;
    logic [WIDTH-1:0] WData;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output D1, D2, Start, Op, HIWe, LOWe, WData,
        input  Busy, Done, HI, LO
    );

    modport slave (
        input  D1, D2, Start, Op, HIWe, LOWe, WData,
        output Busy, Done, HI, LO
    );
endinterface

// File: rtl/md_unit_param.sv
// Multi-cycle multiply/divide unit with HI/LO result registers and MTHI/MTLO writes.
// Busy covers a fixed per-operation latency; Done pulses on the cycle the result lands.
module md_unit_param #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input logic               clk,
    input logic               reset,
    md_unit_param_if.slave    bus
);
    localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int unsigned PROD_W     = 2 * WIDTH;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [PROD_W-1:0]  a_ext, b_ext, prod;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   div_a, div_b, uq, ur;
    logic [WIDTH-1:0]   quot, rem;
    logic [WIDTH-1:0]   res_hi, res_lo;

    // Product: sign- or zero-extend to full width; the low 2W bits are exact either way.
    always_comb begin
        a_ext = op_q[0] ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        b_ext = op_q[0] ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod  = a_ext * b_ext;
    end

    // Divide on magnitudes, then restore signs; most-negative / -1 wraps to itself with zero remainder.
    always_comb begin
        neg_a = op_q[0] & a_q[WIDTH-1];
        neg_b = op_q[0] & b_q[WIDTH-1];
        div_a = neg_a ? WIDTH'(-a_q) : a_q;
        if (b_q == '0) begin
            div_b = WIDTH'(1);
        end else begin
            div_b = neg_b ? WIDTH'(-b_q) : b_q;
        end
        uq = div_a / div_b;
        ur = div_a % div_b;
        if (b_q == '0) begin
            quot = '1;
            rem  = a_q;
        end else begin
            quot = (neg_a ^ neg_b) ? WIDTH'(-uq) : uq;
            rem  = neg_a ? WIDTH'(-ur) : ur;
        end
    end

    always_comb begin
        res_hi = op_q[1] ? rem  : prod[PROD_W-1:WIDTH];
        res_lo = op_q[1] ? quot : prod[WIDTH-1:0];
    end

    // Next-state and register updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    a_d     = bus.D1;
                    b_d     = bus.D2;
                    op_d    = bus.Op;
                    cnt_d   = bus.Op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                    state_d = RUN;
                end else begin
                    if (bus.HIWe) hi_d = bus.WData;
                    if (bus.LOWe) lo_d = bus.WData;
                end
            end
            RUN: begin
                if (cnt_q <= CNT_W'(1)) begin
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.Busy = busy_q;
    assign bus.Done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule

// File: tb/tb_md_unit_param.sv
// Bench for md_unit_param: directed cases plus randomized ops against an integer-arithmetic model.
module tb_md_unit_param;
    localparam int unsigned W  = 16;
    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_unit_param_if #(.WIDTH(W)) bus ();

    md_unit_param #(.WIDTH(W), .MUL_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values.
    task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] hi, output logic [W-1:0] lo);
        longint p, q, r, sa, sb;
        case (op)
            2'b00: begin
                p  = longint'(a) * longint'(b);
                hi = p[31:16];
                lo = p[15:0];
            end
            2'b01: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = sa * sb;
                hi = p[31:16];
                lo = p[15:0];
            end
            2'b10: begin
                if (b == 0) begin
                    lo = 16'hFFFF; hi = a;
                end else begin
                    q = longint'(a) / longint'(b);
                    r = longint'(a) % longint'(b);
                    lo = q[15:0]; hi = r[15:0];
                end
            end
            default: begin
                if (b == 0) begin
                    lo = 16'hFFFF; hi = a;
                end else begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q  = sa / sb;
                    r  = sa % sb;
                    lo = q[15:0]; hi = r[15:0];
                end
            end
        endcase
    endtask

    task automatic clear_ctl();
        bus.Start = 1'b0;
        bus.HIWe  = 1'b0;
        bus.LOWe  = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge of the Done cycle with controls cleared.
    // noise: 0 quiet, 1 random inputs while busy, 2 Start+HIWe with WData=5555 while busy.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int noise, input bit lowe_with_start);
        int n;
        logic [W-1:0] rh, rl;
        n = op[1] ? int'(DC) : int'(MC);
        model(op, a, b, rh, rl);
        bus.Op    = op;
        bus.D1    = a;
        bus.D2    = b;
        bus.Start = 1'b1;
        bus.HIWe  = 1'b0;
        bus.LOWe  = lowe_with_start;
        bus.WData = W'($urandom);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            check($sformatf("busy op%0d c%0d", op, i), 32'(bus.Busy), 32'd1);
            check($sformatf("done_early op%0d c%0d", op, i), 32'(bus.Done), 32'd0);
            check($sformatf("hold_hi op%0d c%0d", op, i), 32'(bus.HI), 32'(exp_hi));
            check($sformatf("hold_lo op%0d c%0d", op, i), 32'(bus.LO), 32'(exp_lo));
            if (noise == 1) begin
                bus.D1    = W'($urandom);
                bus.D2    = W'($urandom);
                bus.Op    = 2'($urandom);
                bus.Start = 1'($urandom);
                bus.HIWe  = 1'($urandom);
                bus.LOWe  = 1'($urandom);
                bus.WData = W'($urandom);
            end else if (noise == 2) begin
                bus.Start = 1'b1;
                bus.HIWe  = 1'b1;
                bus.WData = 16'h5555;
            end else begin
                clear_ctl();
            end
        end
        @(negedge clk);
        exp_hi = rh;
        exp_lo = rl;
        check($sformatf("end_busy op%0d", op), 32'(bus.Busy), 32'd0);
        check($sformatf("done op%0d", op), 32'(bus.Done), 32'd1);
        check($sformatf("hi op%0d %h,%h", op, a, b), 32'(bus.HI), 32'(exp_hi));
        check($sformatf("lo op%0d %h,%h", op, a, b), 32'(bus.LO), 32'(exp_lo));
        clear_ctl();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_done", 32'(bus.Done), 32'd0);
            check("idle_busy", 32'(bus.Busy), 32'd0);
        end
    endtask

    task automatic mt(input bit hiwe, input bit lowe, input logic [W-1:0] d);
        bus.HIWe  = hiwe;
        bus.LOWe  = lowe;
        bus.WData = d;
        @(negedge clk);
        if (hiwe) exp_hi = d;
        if (lowe) exp_lo = d;
        check("mt_hi", 32'(bus.HI), 32'(exp_hi));
        check("mt_lo", 32'(bus.LO), 32'(exp_lo));
        check("mt_busy", 32'(bus.Busy), 32'd0);
        clear_ctl();
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            3:       return 16'h0001;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        bit seen_done;
        reset     = 1'b1;
        bus.D1    = '0;
        bus.D2    = '0;
        bus.Op    = '0;
        bus.WData = '0;
        clear_ctl();
        repeat (2) @(negedge clk);
        check("rst_hi", 32'(bus.HI), 32'd0);
        check("rst_lo", 32'(bus.LO), 32'd0);
        check("rst_busy", 32'(bus.Busy), 32'd0);
        check("rst_done", 32'(bus.Done), 32'd0);
        reset = 1'b0;
        idle(1);

        run_op(2'b00, 16'hFFFF, 16'hFFFF, 0, 1'b0);
        check("t1_hi_const", 32'(bus.HI), 32'h0000FFFE);
        check("t1_lo_const", 32'(bus.LO), 32'h00000001);
        idle(1);
        run_op(2'b01, 16'hFFFE, 16'h0003, 0, 1'b0);
        check("t2_hi_const", 32'(bus.HI), 32'h0000FFFF);
        check("t2_lo_const", 32'(bus.LO), 32'h0000FFFA);
        run_op(2'b00, 16'h0002, 16'h0003, 0, 1'b0);
        check("t2b_lo_const", 32'(bus.LO), 32'h00000006);
        idle(1);
        run_op(2'b11, 16'hFFF9, 16'h0002, 0, 1'b0);
        check("t3_lo_const", 32'(bus.LO), 32'h0000FFFD);
        check("t3_hi_const", 32'(bus.HI), 32'h0000FFFF);
        run_op(2'b10, 16'hFFF9, 16'h0002, 0, 1'b0);
        check("t3b_lo_const", 32'(bus.LO), 32'h00007FFC);
        check("t3b_hi_const", 32'(bus.HI), 32'h00000001);
        run_op(2'b10, 16'h1234, 16'h0000, 0, 1'b0);
        check("t4_lo_const", 32'(bus.LO), 32'h0000FFFF);
        check("t4_hi_const", 32'(bus.HI), 32'h00001234);
        run_op(2'b11, 16'h8000, 16'hFFFF, 0, 1'b0);
        check("t4b_lo_const", 32'(bus.LO), 32'h00008000);
        check("t4b_hi_const", 32'(bus.HI), 32'h00000000);
        idle(1);
        mt(1'b1, 1'b0, 16'h00AA);
        mt(1'b1, 1'b1, 16'h1357);
        run_op(2'b01, 16'h0123, 16'hFF00, 2, 1'b0);
        idle(1);
        run_op(2'b00, 16'h0010, 16'h0020, 0, 1'b1);
        check("t5_lo_const", 32'(bus.LO), 32'h00000200);
        idle(2);

        // Abort a DIV in its 3rd busy cycle.
        bus.Op = 2'b11; bus.D1 = 16'h7777; bus.D2 = 16'h0003; bus.Start = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("abort_busy", 32'(bus.Busy), 32'd1);
            clear_ctl();
        end
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        check("abort_busy_low", 32'(bus.Busy), 32'd0);
        check("abort_hi", 32'(bus.HI), 32'd0);
        check("abort_lo", 32'(bus.LO), 32'd0);
        seen_done = bus.Done;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            seen_done |= bus.Done;
        end
        check("abort_no_done", 32'(seen_done), 32'd0);

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                mt(1'($urandom), 1'($urandom), W'($urandom));
            end else begin
                run_op(2'($urandom), pick(), pick(), int'($urandom_range(0, 1)), 1'($urandom));
            end
            idle(int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
